// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive buffer.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [0:0] {
      CAP_IDLE  = 1'b0,
      CAP_CLEAR = 1'b1
   } cap_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers wrap naturally (DEPTH is a power of two).
module uart_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              pop_eff, push_eff;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == FULL_CNT);
   assign count_o = cnt_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_q];

   // A push into a full FIFO is legal only when the head leaves on the same edge.
   assign pop_eff  = pop_i & ~empty_o;
   assign push_eff = push_i & (~full_o | pop_eff);

   always_comb begin
      wr_d  = push_eff ? AW'(wr_q + 1'b1) : wr_q;
      rd_d  = pop_eff  ? AW'(rd_q + 1'b1) : rd_q;
      cnt_d = cnt_q;
      case ({push_eff, pop_eff})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_eff) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_rx_buffer.sv
// Captures receiver words on RXNE, handshakes the clear, buffers them in a FIFO and
// counts drops and overruns.
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        in_word,
   input  logic                     in_RXNE,
   output logic                     out_RXNE_clear,
   input  logic                     in_Rx_ORE,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     in_ready,
   output logic [$clog2(DEPTH):0]   out_count,
   output logic                     out_full,
   output logic                     out_empty,
   output logic [7:0]               out_drop_cnt,
   output logic [7:0]               out_ore_cnt
);

   cap_state_e state_q, state_d;
   logic       capture, pop, push_ok;
   logic [7:0] drop_q, drop_d, ore_cnt_q, ore_cnt_d;
   logic       ore_q;

   assign capture   = (state_q == CAP_IDLE) & in_RXNE;
   assign out_valid = ~out_empty;
   assign pop       = out_valid & in_ready;
   assign push_ok   = capture & (~out_full | pop);

   // Clear is a decoded register bit: high for the whole CLEAR state only.
   assign out_RXNE_clear = (state_q == CAP_CLEAR);
   assign out_drop_cnt   = drop_q;
   assign out_ore_cnt    = ore_cnt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         CAP_IDLE:  if (in_RXNE)  state_d = CAP_CLEAR;
         CAP_CLEAR: if (!in_RXNE) state_d = CAP_IDLE;
         default:   state_d = CAP_IDLE;
      endcase
   end

   always_comb begin
      drop_d = drop_q;
      if (capture && !push_ok && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      ore_cnt_d = ore_cnt_q;
      if (in_Rx_ORE && !ore_q && ore_cnt_q != 8'hFF) ore_cnt_d = ore_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CAP_IDLE;
         drop_q    <= '0;
         ore_cnt_q <= '0;
         ore_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         drop_q    <= drop_d;
         ore_cnt_q <= ore_cnt_d;
         ore_q     <= in_Rx_ORE;
      end
   end

   uart_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_ok),
      .wdata_i (in_word),
      .pop_i   (pop),
      .rdata_o (out_data),
      .count_o (out_count),
      .full_o  (out_full),
      .empty_o (out_empty)
   );

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer (DEPTH=8, DATA_W=8).
module tb_uart_rx_buffer;

   logic       clk;
   logic       rst;
   logic [7:0] in_word;
   logic       in_RXNE;
   logic       out_RXNE_clear;
   logic       in_Rx_ORE;
   logic [7:0] out_data;
   logic       out_valid;
   logic       in_ready;
   logic [3:0] out_count;
   logic       out_full;
   logic       out_empty;
   logic [7:0] out_drop_cnt;
   logic [7:0] out_ore_cnt;

   int vecs = 0;
   int errs = 0;

   uart_rx_buffer #(.DEPTH(8), .DATA_W(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_word        (in_word),
      .in_RXNE        (in_RXNE),
      .out_RXNE_clear (out_RXNE_clear),
      .in_Rx_ORE      (in_Rx_ORE),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .in_ready       (in_ready),
      .out_count      (out_count),
      .out_full       (out_full),
      .out_empty      (out_empty),
      .out_drop_cnt   (out_drop_cnt),
      .out_ore_cnt    (out_ore_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full RXNE handshake: capture edge, one CLEAR cycle, then RXNE drops.
   task automatic deliver(input logic [7:0] w);
      in_word = w;
      in_RXNE = 1'b1;
      tick();
      tick();
      in_RXNE = 1'b0;
      tick();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_count"}, out_count, 0);
      chk({tag, "_empty"}, out_empty, 1);
      chk({tag, "_full"},  out_full, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_clr"},   out_RXNE_clear, 0);
      chk({tag, "_data"},  out_data, 0);
      chk({tag, "_drop"},  out_drop_cnt, 0);
      chk({tag, "_ore"},   out_ore_cnt, 0);
   endtask

   initial begin
      rst = 1'b1; in_word = '0; in_RXNE = 1'b0; in_Rx_ORE = 1'b0; in_ready = 1'b0;
      #1;
      chk_reset_vals("rst0");
      tick(); tick();
      rst = 1'b0;
      tick();

      // single capture, latency and clear handshake
      in_word = 8'h36; in_RXNE = 1'b1;
      chk("pre_clr", out_RXNE_clear, 0);
      tick();
      chk("cap_clr", out_RXNE_clear, 1);
      chk("cap_valid", out_valid, 1);
      chk("cap_data", out_data, 8'h36);
      chk("cap_count", out_count, 1);
      tick();
      chk("hold_clr", out_RXNE_clear, 1);
      chk("no_double", out_count, 1);
      in_RXNE = 1'b0;
      tick();
      chk("rel_clr", out_RXNE_clear, 0);
      chk("rel_count", out_count, 1);

      // ordered drain of two words, then pop on empty is ignored
      deliver(8'h78);
      chk("two_count", out_count, 2);
      in_ready = 1'b1;
      chk("pop0_data", out_data, 8'h36);
      tick();
      chk("pop1_data", out_data, 8'h78);
      chk("pop1_count", out_count, 1);
      tick();
      chk("drain_empty", out_empty, 1);
      chk("drain_valid", out_valid, 0);
      tick();
      chk("empty_pop_cnt", out_count, 0);
      in_ready = 1'b0;

      // overfill: 10 words into 8 entries
      for (int i = 0; i < 10; i++) deliver(8'hA0 + 8'(i));
      chk("ovf_full", out_full, 1);
      chk("ovf_count", out_count, 8);
      chk("ovf_drop", out_drop_cnt, 2);
      chk("ovf_head", out_data, 8'hA0);

      // capture into full FIFO with simultaneous pop
      in_word = 8'hC5; in_RXNE = 1'b1; in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      chk("fp_count", out_count, 8);
      chk("fp_drop", out_drop_cnt, 2);
      chk("fp_head", out_data, 8'hA1);
      tick();
      in_RXNE = 1'b0;
      tick();
      in_ready = 1'b1;
      for (int i = 1; i < 8; i++) begin
         chk($sformatf("drain%0d", i), out_data, 8'hA0 + 8'(i));
         tick();
      end
      chk("drain_last", out_data, 8'hC5);
      tick();
      chk("drain_done", out_empty, 1);
      in_ready = 1'b0;

      // overrun counter: level held counts once, then saturation
      in_Rx_ORE = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("ore_hold", out_ore_cnt, 1);
      in_Rx_ORE = 1'b0;
      tick();
      for (int i = 0; i < 253; i++) begin
         in_Rx_ORE = 1'b1; tick();
         in_Rx_ORE = 1'b0; tick();
      end
      chk("ore_254", out_ore_cnt, 254);
      for (int i = 0; i < 46; i++) begin
         in_Rx_ORE = 1'b1; tick();
         in_Rx_ORE = 1'b0; tick();
      end
      chk("ore_sat", out_ore_cnt, 255);

      // reset in the middle of a CLEAR handshake
      deliver(8'h11);
      deliver(8'h22);
      in_word = 8'h33; in_RXNE = 1'b1;
      tick();
      chk("mid_count", out_count, 3);
      chk("mid_clr", out_RXNE_clear, 1);
      rst = 1'b1;
      #1;
      chk_reset_vals("rst1");
      in_word = 8'h5B;
      tick();
      rst = 1'b0;
      tick();
      chk("recap_count", out_count, 1);
      chk("recap_data", out_data, 8'h5B);
      chk("recap_clr", out_RXNE_clear, 1);
      tick();
      chk("recap_once", out_count, 1);
      in_RXNE = 1'b0;
      tick();
      chk("recap_rel", out_RXNE_clear, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
